// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control path: FSM states,
// the opcodes the main FSM recognises, and the ALUOp codes sent to the ALU decoder.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECI    = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10
  } state_e;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

endpackage

// File: rtl/multicycle_main_fsm.sv
// Main control FSM of the multicycle RV32I datapath. Moore decode of the state
// register, with memory accesses gated by mem_ready and a sticky illegal-opcode flag.
module multicycle_main_fsm
  import riscv_ctrl_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [6:0]         op,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               adr_src,
  output logic               mem_write,
  output logic               ir_write,
  output logic [1:0]         result_src,
  output logic [1:0]         alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         alu_op,
  output logic               reg_write,
  output logic               illegal_op,
  output logic               retire,
  output logic [STATE_W-1:0] state
);

  state_e state_q, state_d;
  logic   illegal_q, illegal_d;
  logic   pc_update, branch, rdy;

  // While in reset the state already reads S_FETCH; masking mem_ready keeps
  // the fetch enables low until reset is released.
  assign rdy = mem_ready & reset_n;

  always_comb begin
    state_d    = state_q;
    illegal_d  = illegal_q;
    pc_update  = 1'b0;
    branch     = 1'b0;
    adr_src    = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    result_src = 2'b00;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = ALUOP_ADD;
    reg_write  = 1'b0;
    retire     = 1'b0;
    case (state_q)
      S_FETCH: begin
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_write   = rdy;
        pc_update  = rdy;
        if (rdy) state_d = S_DECODE;
      end
      S_DECODE: begin
        // Precompute the branch target into ALUOut
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECR;
          OP_I:         state_d = S_EXECI;
          OP_BEQ:       state_d = S_BEQ;
          OP_JAL:       state_d = S_JAL;
          default: begin
            state_d   = S_FETCH;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        state_d   = op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
        if (rdy) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        retire     = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
        retire    = rdy;
        if (rdy) state_d = S_FETCH;
      end
      S_EXECR: begin
        alu_src_a = 2'b10;
        alu_op    = ALUOP_FUNCT;
        state_d   = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = ALUOP_FUNCT;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_BEQ: begin
        alu_src_a = 2'b10;
        alu_op    = ALUOP_SUB;
        branch    = 1'b1;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_update = 1'b1;
        state_d   = S_ALUWB;
      end
      default: state_d = S_FETCH;
    endcase
  end

  assign pc_write   = pc_update | (branch & zero);
  assign illegal_op = illegal_q;
  assign state      = STATE_W'(state_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

endmodule

// File: tb/tb_multicycle_main_fsm.sv
// Directed bench for multicycle_main_fsm: walks each instruction class through
// its state sequence with hand-computed expected controls.
module tb_multicycle_main_fsm;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [6:0] op;
  logic       zero;
  logic       mem_ready;
  logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal_op, retire;
  logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;
  logic [3:0] state;

  int n_cmp = 0;
  int n_err = 0;

  multicycle_main_fsm #(.STATE_W(4)) dut (
    .clk(clk), .reset_n(reset_n), .op(op), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .adr_src(adr_src), .mem_write(mem_write), .ir_write(ir_write),
    .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .reg_write(reg_write), .illegal_op(illegal_op),
    .retire(retire), .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0; op = 7'd0; zero = 1'b0; mem_ready = 1'b1;
    #2;
    chk("rst_state", 32'(state), 0);
    chk("rst_illegal", 32'(illegal_op), 0);
    chk("rst_ir_write", 32'(ir_write), 0);
    chk("rst_pc_write", 32'(pc_write), 0);
    @(posedge clk); #2;
    mem_ready = 1'b0;
    reset_n = 1'b1;
    #1;

    // Fetch stalls while memory is not ready
    for (int i = 0; i < 5; i++) begin
      chk("stall_state", 32'(state), 0);
      chk("stall_ir_write", 32'(ir_write), 0);
      chk("stall_pc_write", 32'(pc_write), 0);
      step();
    end
    mem_ready = 1'b1; #1;
    chk("fetch_ir_write", 32'(ir_write), 1);
    chk("fetch_pc_write", 32'(pc_write), 1);
    chk("fetch_srcb", 32'(alu_src_b), 2);
    chk("fetch_res", 32'(result_src), 2);

    // R-type: 0,1,6,7,0
    op = 7'b0110011;
    step();
    chk("r_decode", 32'(state), 1);
    chk("r_dec_ir_write", 32'(ir_write), 0);
    chk("r_dec_srca", 32'(alu_src_a), 1);
    chk("r_dec_srcb", 32'(alu_src_b), 1);
    chk("r_dec_retire", 32'(retire), 0);
    step();
    chk("r_exec", 32'(state), 6);
    chk("r_exec_aluop", 32'(alu_op), 2);
    chk("r_exec_srca", 32'(alu_src_a), 2);
    chk("r_exec_srcb", 32'(alu_src_b), 0);
    chk("r_exec_regw", 32'(reg_write), 0);
    chk("r_exec_retire", 32'(retire), 0);
    step();
    chk("r_wb", 32'(state), 7);
    chk("r_wb_regw", 32'(reg_write), 1);
    chk("r_wb_retire", 32'(retire), 1);
    chk("r_wb_res", 32'(result_src), 0);
    step();
    chk("r_back", 32'(state), 0);
    chk("r_back_retire", 32'(retire), 0);

    // lw with 3 wait cycles in MEMREAD
    op = 7'b0000011;
    step();
    chk("lw_decode", 32'(state), 1);
    step();
    chk("lw_memadr", 32'(state), 2);
    chk("lw_memadr_srca", 32'(alu_src_a), 2);
    chk("lw_memadr_srcb", 32'(alu_src_b), 1);
    mem_ready = 1'b0;
    step();
    for (int i = 0; i < 3; i++) begin
      chk("lw_wait_state", 32'(state), 3);
      chk("lw_wait_adr", 32'(adr_src), 1);
      chk("lw_wait_regw", 32'(reg_write), 0);
      step();
    end
    chk("lw_read_state", 32'(state), 3);
    mem_ready = 1'b1;
    step();
    chk("lw_memwb", 32'(state), 4);
    chk("lw_memwb_res", 32'(result_src), 1);
    chk("lw_memwb_regw", 32'(reg_write), 1);
    chk("lw_memwb_retire", 32'(retire), 1);
    step();
    chk("lw_back", 32'(state), 0);

    // beq taken
    op = 7'b1100011; zero = 1'b1;
    step();
    step();
    chk("beq_state", 32'(state), 10);
    chk("beq_aluop", 32'(alu_op), 1);
    chk("beq_taken_pcw", 32'(pc_write), 1);
    chk("beq_retire", 32'(retire), 1);
    zero = 1'b0; #1;
    chk("beq_zero_drop_pcw", 32'(pc_write), 0);
    step();
    chk("beq_back", 32'(state), 0);
    // beq not taken
    step();
    step();
    chk("beq2_state", 32'(state), 10);
    chk("beq2_pcw", 32'(pc_write), 0);
    step();
    chk("beq2_back", 32'(state), 0);

    // Illegal opcode, then an I-type still executes
    op = 7'b0000000;
    step();
    chk("ill_decode", 32'(state), 1);
    chk("ill_pre_flag", 32'(illegal_op), 0);
    step();
    chk("ill_back", 32'(state), 0);
    chk("ill_flag", 32'(illegal_op), 1);
    chk("ill_retire", 32'(retire), 0);
    op = 7'b0010011;
    step();
    step();
    chk("i_exec", 32'(state), 8);
    chk("i_exec_aluop", 32'(alu_op), 2);
    chk("i_exec_srcb", 32'(alu_src_b), 1);
    step();
    chk("i_wb", 32'(state), 7);
    chk("i_wb_retire", 32'(retire), 1);
    step();
    chk("i_back", 32'(state), 0);
    chk("i_flag_sticky", 32'(illegal_op), 1);

    // jal
    op = 7'b1101111;
    step();
    step();
    chk("jal_state", 32'(state), 9);
    chk("jal_pcw", 32'(pc_write), 1);
    chk("jal_srca", 32'(alu_src_a), 1);
    chk("jal_srcb", 32'(alu_src_b), 2);
    chk("jal_retire", 32'(retire), 0);
    step();
    chk("jal_wb", 32'(state), 7);
    step();

    // sw with one wait cycle, then reset mid-MEMWRITE
    op = 7'b0100011;
    step();
    step();
    chk("sw_memadr", 32'(state), 2);
    mem_ready = 1'b0;
    step();
    chk("sw_state", 32'(state), 5);
    chk("sw_memw", 32'(mem_write), 1);
    chk("sw_adr", 32'(adr_src), 1);
    chk("sw_wait_retire", 32'(retire), 0);
    step();
    chk("sw_hold", 32'(state), 5);
    mem_ready = 1'b1; #1;
    chk("sw_ready_retire", 32'(retire), 1);
    reset_n = 1'b0; #1;
    chk("arst_state", 32'(state), 0);
    chk("arst_memw", 32'(mem_write), 0);
    chk("arst_illegal", 32'(illegal_op), 0);
    chk("arst_ir_write", 32'(ir_write), 0);
    mem_ready = 1'b0;
    #1 reset_n = 1'b1; #1;
    step();
    chk("post_rst_state", 32'(state), 0);
    chk("post_rst_memw", 32'(mem_write), 0);
    chk("post_rst_regw", 32'(reg_write), 0);
    chk("post_rst_irw", 32'(ir_write), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/multicycle_main_fsm.md
Name: multicycle_main_fsm

Overview:
- Main control FSM for the multicycle RV32I datapath; sits directly upstream of the ALU decoder and drives its 2-bit ALUOp.
- Sequences each instruction through Fetch/Decode/Execute/Memory/Writeback.
- Produces datapath mux selects and write enables.
- Handles a memory ready handshake, flags illegal opcodes and emits a retire pulse.

Parameters:
- STATE_W, 4, width of state register and debug port.

Ports:
- clk  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- op  in  7  instruction opcode, bits [6:0] of the instruction register.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current access this cycle.
- pc_write  out  1  PC enable: pc_update | (branch & zero).
- adr_src  out  1  memory address select: 0 = PC, 1 = ALU result.
- mem_write  out  1  data memory write enable.
- ir_write  out  1  instruction register and OldPC enable.
- result_src  out  2  result mux: 00 = ALUOut, 01 = data, 10 = ALU result.
- alu_src_a  out  2  00 = PC, 01 = OldPC, 10 = rs1 data.
- alu_src_b  out  2  00 = rs2 data, 01 = immediate, 10 = constant 4.
- alu_op  out  2  to the ALU decoder: 00 = add, 01 = sub, 10 = funct-decoded.
- reg_write  out  1  register file write enable.
- illegal_op  out  1  sticky flag, set on an unsupported opcode in Decode.
- retire  out  1  one-cycle pulse when an instruction completes.
- state  out  STATE_W  current state (debug).

Behaviour:
- Moore FSM. All outputs decode combinationally from the state register, except the mem_ready gating and pc_write noted below.
- Async reset: state = S_FETCH, illegal_op = 0.
- Outputs while reset_n = 0 equal the S_FETCH decode with mem_ready forced to 0, so all enables are 0.
- Any output not listed for a state is 0.
- S_FETCH:
  - adr_src = 0, alu_src_a = 00, alu_src_b = 10, alu_op = 00, result_src = 10.
  - ir_write and pc_update = mem_ready.
  - Stays in S_FETCH while !mem_ready, else -> S_DECODE.
- S_DECODE:
  - alu_src_a = 01, alu_src_b = 01, alu_op = 00 (branch target into ALUOut).
  - Next state by op:
    - 0000011 or 0100011 -> S_MEMADR.
    - 0110011 -> S_EXECR.
    - 0010011 -> S_EXECI.
    - 1100011 -> S_BEQ.
    - 1101111 -> S_JAL.
    - Any other op -> S_FETCH, set illegal_op, no retire.
- S_MEMADR:
  - alu_src_a = 10, alu_src_b = 01, alu_op = 00.
  - op[5] = 0 -> S_MEMREAD, op[5] = 1 -> S_MEMWRITE.
- S_MEMREAD: adr_src = 1, result_src = 00. Waits for mem_ready, then -> S_MEMWB.
- S_MEMWB: result_src = 01, reg_write = 1, retire = 1 -> S_FETCH.
- S_MEMWRITE:
  - adr_src = 1, result_src = 00, mem_write held at 1.
  - Waits for mem_ready; retire = mem_ready; then -> S_FETCH.
- S_EXECR: alu_src_a = 10, alu_src_b = 00, alu_op = 10 -> S_ALUWB.
- S_EXECI: alu_src_a = 10, alu_src_b = 01, alu_op = 10 -> S_ALUWB.
- S_ALUWB: result_src = 00, reg_write = 1, retire = 1 -> S_FETCH.
- S_BEQ:
  - alu_src_a = 10, alu_src_b = 00, alu_op = 01, result_src = 00, branch = 1.
  - pc_write = zero; retire = 1 -> S_FETCH.
- S_JAL:
  - alu_src_a = 01, alu_src_b = 10, alu_op = 00, result_src = 00, pc_update = 1 -> S_ALUWB.
- illegal_op stays set until reset.
- An unencoded state value (11-15) returns to S_FETCH with all outputs 0.
- Reset asserted mid-instruction aborts immediately. No write enable may be high in the cycle after reset_n deasserts unless mem_ready = 1 in S_FETCH.
- CPI: R/I-type 4, beq 3, jal 4, sw 4, lw 5, each plus memory wait cycles.

Decomposition:
- Package riscv_ctrl_pkg holds:
  - state encodings: S_FETCH = 0, S_DECODE = 1, S_MEMADR = 2, S_MEMREAD = 3, S_MEMWB = 4, S_MEMWRITE = 5, S_EXECR = 6, S_ALUWB = 7, S_EXECI = 8, S_JAL = 9, S_BEQ = 10;
  - opcode constants OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL;
  - ALUOp constants ALUOP_ADD = 00, ALUOP_SUB = 01, ALUOP_FUNCT = 10.
- Single module; the state-to-output decode is one case statement with no sub-module.
- Top-level control instantiates this block alongside the ALU decoder and the immediate-source decoder.

Test Plan:
- Reset with reset_n = 0 mid-S_MEMWRITE, mem_ready = 1 -> state = 0 and mem_write = 0 asynchronously; illegal_op = 0.
- op = 0110011, mem_ready = 1 always -> state sequence 0,1,6,7,0; alu_op = 10 in S_EXECR; reg_write = 1 and retire = 1 only in S_ALUWB.
- op = 0000011, mem_ready low for 3 cycles in S_MEMREAD -> holds state 3 with adr_src = 1 for 3 cycles, then 4 with result_src = 01 and reg_write = 1.
- op = 1100011: with zero = 1 -> pc_write = 1 in S_BEQ and alu_op = 01; with zero = 0 -> pc_write = 0; both return to S_FETCH.
- op = 0000000 -> S_DECODE goes to S_FETCH, illegal_op = 1, retire stays 0; a following op = 0010011 executes normally and illegal_op remains 1.
- mem_ready = 0 for 5 cycles after reset -> remains in S_FETCH with ir_write = 0 and pc_write = 0; mem_ready = 1 -> ir_write = 1 and pc_write = 1 for exactly one cycle.
